wm_apb_sequencer: RTL

//  Controller that programs and runs the Visible_Watermarking core.
//  - Accepts config words (addr/data) over a valid/ready port.
//  - Issues each word as an APB write to the core.
//  - Writes the START value to the control register.
//  - Counts new_pixel pulses until Image_Done, with a cycle timeout.
//  - Sits between the stimulus/host side and the core's APB slave port.

---
 rtl/wm_apb_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wm_apb_sequencer.sv
// Programs the Visible_Watermarking core over APB, issues START, then supervises
// the image run (pixel count, done / timeout pulses).
module wm_apb_sequencer #(
    parameter int                          Amba_Addr_Depth = 20,
    parameter int                          Amba_Word       = 16,
    parameter logic [Amba_Addr_Depth-1:0]  CTRL_ADDR       = '0,
    parameter logic [Amba_Word-1:0]        START_VAL       = Amba_Word'(1),
    parameter int                          PIX_CNT_W       = 16,
    parameter int                          TIMEOUT_W       = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [Amba_Addr_Depth-1:0]  cfg_addr,
    input  logic [Amba_Word-1:0]        cfg_data,
    input  logic                        cfg_last,
    input  logic [TIMEOUT_W-1:0]        timeout_limit,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [Amba_Addr_Depth-1:0]  PADDR,
    output logic [Amba_Word-1:0]        PWDATA,
    input  logic                        new_pixel,
    input  logic                        Image_Done,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    output logic [PIX_CNT_W-1:0]        pixel_count
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CFG_SETUP  = 3'd1;
    localparam logic [2:0] S_CFG_ACCESS = 3'd2;
    localparam logic [2:0] S_ST_SETUP   = 3'd3;
    localparam logic [2:0] S_ST_ACCESS  = 3'd4;
    localparam logic [2:0] S_RUN        = 3'd5;

    logic [2:0]                 state, state_nxt;
    logic [Amba_Addr_Depth-1:0] addr_q;
    logic [Amba_Word-1:0]       data_q;
    logic                       last_q;
    logic [TIMEOUT_W-1:0]       tmo_cnt;

    logic                       accept;
    logic                       in_run;
    logic                       tmo_hit;
    logic                       pix_sat;

    logic                       sel_nxt, en_nxt;
    logic [Amba_Addr_Depth-1:0] paddr_nxt;
    logic [Amba_Word-1:0]       pwdata_nxt;

    // cfg_ready is itself registered, so the first cycle after reset never accepts
    assign accept  = (state == S_IDLE) && cfg_ready && cfg_valid;
    assign in_run  = (state == S_RUN);
    assign tmo_hit = (timeout_limit != '0) &&
                     (tmo_cnt == timeout_limit - TIMEOUT_W'(1));
    assign pix_sat = &pixel_count;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept) state_nxt = S_CFG_SETUP;
            S_CFG_SETUP:  state_nxt = S_CFG_ACCESS;
            S_CFG_ACCESS: state_nxt = last_q ? S_ST_SETUP : S_IDLE;
            S_ST_SETUP:   state_nxt = S_ST_ACCESS;
            S_ST_ACCESS:  state_nxt = S_RUN;
            S_RUN:        if (Image_Done || tmo_hit) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // APB pins are flops decoded from the next state; the word being latched
    // this edge is taken straight from the config port.
    always_comb begin
        sel_nxt    = 1'b0;
        en_nxt     = 1'b0;
        paddr_nxt  = '0;
        pwdata_nxt = '0;
        case (state_nxt)
            S_CFG_SETUP, S_CFG_ACCESS: begin
                sel_nxt    = 1'b1;
                en_nxt     = (state_nxt == S_CFG_ACCESS);
                paddr_nxt  = accept ? cfg_addr : addr_q;
                pwdata_nxt = accept ? cfg_data : data_q;
            end
            S_ST_SETUP, S_ST_ACCESS: begin
                sel_nxt    = 1'b1;
                en_nxt     = (state_nxt == S_ST_ACCESS);
                paddr_nxt  = CTRL_ADDR;
                pwdata_nxt = START_VAL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            cfg_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_ready   <= (state_nxt == S_IDLE);
            busy        <= (state_nxt != S_IDLE);
            PSEL        <= sel_nxt;
            PENABLE     <= en_nxt;
            PWRITE      <= sel_nxt;
            PADDR       <= paddr_nxt;
            PWDATA      <= pwdata_nxt;
            // Image_Done has priority, so the two pulses are mutually exclusive
            done        <= in_run && Image_Done;
            err_timeout <= in_run && !Image_Done && tmo_hit;
            if (accept) begin
                addr_q <= cfg_addr;
                data_q <= cfg_data;
                last_q <= cfg_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
            tmo_cnt     <= '0;
        end else if (state == S_ST_ACCESS) begin
            pixel_count <= '0;
            tmo_cnt     <= '0;
        end else if (in_run) begin
            if (new_pixel && !pix_sat)
                pixel_count <= pixel_count + PIX_CNT_W'(1);
            if (!Image_Done && !tmo_hit)
                tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
    end

endmodule
